seg7_display_ctrl: RTL and testbench

Parametrised multi-digit seven-segment display controller for the DE10-Lite board, driving NDIG static active-low digits (segments plus decimal point). It captures a display value on a load strobe and shows it either as hex or as decimal; decimal values are converted by an iterative shift-add-3 engine with a BUSY handshake. It also provides per-digit enable, per-digit blink, decimal-point control and leading-zero blanking. It sits between the datapath's debug/status registers and the HEXn pins.

---
 rtl/seg7_display_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - multi-digit seven-segment display controller with hex/decimal modes
//
// Drives NDIG static, active-low seven-segment digits (plus decimal point).
// A LOAD strobe captures a value that is shown either as raw hex nibbles or,
// in decimal mode, after an iterative shift-add-3 (double-dabble) conversion.
//
// Ports:
//   CLK    - system clock, all state on the rising edge
//   nRST   - asynchronous active-low reset
//   LOAD   - single-cycle strobe capturing DIN, DOT and MODE (ignored while BUSY)
//   DIN    - display value; nibble i drives digit i in hex mode,
//            DIN[BIN_W-1:0] is the unsigned binary value in decimal mode
//   MODE   - 0 = hex, 1 = decimal
//   DOT    - decimal point per digit, 1 = lit (captured with LOAD)
//   EN     - live per-digit enable
//   BLINK  - live per-digit blink enable
//   LZB    - live leading-zero blanking enable
//   BUSY   - decimal conversion in progress
//   nHEX   - registered segment outputs, digit i = nHEX[8i+7:8i] = {dp,g,f,e,d,c,b,a}

module seg7_display_ctrl #(
    parameter int NDIG      = 6,
    parameter int BIN_W     = 20,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              LOAD,
    input  logic [4*NDIG-1:0] DIN,
    input  logic              MODE,
    input  logic [NDIG-1:0]   DOT,
    input  logic [NDIG-1:0]   EN,
    input  logic [NDIG-1:0]   BLINK,
    input  logic              LZB,
    output logic              BUSY,
    output logic [8*NDIG-1:0] nHEX
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // One spare BCD digit above the display catches values that do not fit.
    localparam int BCD_W = 4 * (NDIG + 1);
    localparam int SW    = $clog2(BIN_W + 1);
    localparam int CW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] LAST_STEP = SW'(BIN_W - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(BLINK_DIV - 1);

    logic [1:0]        state;
    logic [BIN_W-1:0]  bin_sr;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W:0]    shifted;
    logic              sticky;
    logic              commit_ovf;
    logic [SW-1:0]     step;
    logic [NDIG-1:0]   dot_hold;

    logic [4*NDIG-1:0] shadow_val;
    logic [NDIG-1:0]   shadow_dot;
    logic              shadow_ovf;

    logic [CW-1:0]     blink_cnt;
    logic              blink_on;

    logic [8*NDIG-1:0] nhex_next;

    // Segment pattern (g..a, active-low) for one hex nibble.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // Double-dabble correction: every BCD digit >= 5 gets 3 added before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i <= NDIG; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Bit BCD_W is the bit shifted out of the top BCD digit.
    assign shifted    = {bcd_adj, bin_sr[BIN_W-1]};
    assign commit_ovf = sticky | (bcd[4*NDIG +: 4] != 4'd0);
    assign BUSY       = (state != S_IDLE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= S_IDLE;
            bin_sr     <= '0;
            bcd        <= '0;
            sticky     <= 1'b0;
            step       <= '0;
            dot_hold   <= '0;
            shadow_val <= '0;
            shadow_dot <= '0;
            shadow_ovf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (LOAD) begin
                        if (!MODE) begin
                            shadow_val <= DIN;
                            shadow_dot <= DOT;
                            shadow_ovf <= 1'b0;
                        end else begin
                            bin_sr   <= DIN[BIN_W-1:0];
                            dot_hold <= DOT;
                            bcd      <= '0;
                            sticky   <= 1'b0;
                            step     <= '0;
                            state    <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    bcd    <= shifted[BCD_W-1:0];
                    sticky <= sticky | shifted[BCD_W];
                    bin_sr <= bin_sr << 1;
                    step   <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // Whole display updates in one edge so no partial value is ever shown.
                    shadow_val <= bcd[4*NDIG-1:0];
                    shadow_dot <= dot_hold;
                    shadow_ovf <= commit_ovf;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running blink timebase shared by all digits; phase flips on each wrap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == CNT_MAX) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Digits are scanned from the top down; zero_run stays set while every
    // digit seen so far (this one included) is zero, which marks a leading zero.
    always_comb begin
        logic       zero_run;
        logic [6:0] seg;
        nhex_next = '1;
        zero_run  = 1'b1;
        seg       = 7'h7F;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_run = zero_run & (shadow_val[4*i +: 4] == 4'd0);
            if (shadow_ovf) begin
                seg = 7'h3F;
            end else if (LZB && zero_run && (i != 0)) begin
                seg = 7'h7F;
            end else begin
                seg = glyph(shadow_val[4*i +: 4]);
            end
            if (EN[i] && !(BLINK[i] && !blink_on)) begin
                nhex_next[8*i +: 8] = {~shadow_dot[i], seg};
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            nHEX <= '1;
        end else begin
            nHEX <= nhex_next;
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - scoreboard testbench for seg7_display_ctrl
`timescale 1ns/1ps
module tb_seg7_display_ctrl;

    localparam int NDIG  = 6;
    localparam int BIN_W = 20;
    localparam int BD    = 4;
    localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        CLK   = 1'b0;
    logic        nRST  = 1'b0;
    logic        LOAD  = 1'b0;
    logic [23:0] DIN   = '0;
    logic        MODE  = 1'b0;
    logic [5:0]  DOT   = '0;
    logic [5:0]  EN    = '1;
    logic [5:0]  BLINK = '0;
    logic        LZB   = 1'b0;
    logic        BUSY;
    logic [47:0] nHEX;

    seg7_display_ctrl #(.NDIG(NDIG), .BIN_W(BIN_W), .BLINK_DIV(BD)) dut (
        .CLK(CLK), .nRST(nRST), .LOAD(LOAD), .DIN(DIN), .MODE(MODE), .DOT(DOT),
        .EN(EN), .BLINK(BLINK), .LZB(LZB), .BUSY(BUSY), .nHEX(nHEX)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic [47:0] hex;
        logic        busy;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   cyc  = 0;
    int   bcnt = 0;
    int   total = 0;
    int   bad   = 0;
    bit   drain_timeout = 0;
    bit   drain_counted = 0;

    // Reference display contents
    int        m_dig [NDIG];
    bit        m_ovf;
    logic [5:0] m_dot;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) bcnt <= 0;
        else       bcnt <= bcnt + 1;
    end

    // Expected nHEX for the edge that is the m-th since reset release.
    function automatic logic [47:0] model_hex(input int m);
        logic [47:0] r;
        logic [7:0]  g;
        bit          on;
        int          msd;
        on  = (((m - 1) / BD) % 2) == 0;
        msd = 0;
        for (int i = 0; i < NDIG; i++) if (m_dig[i] != 0) msd = i;
        for (int i = 0; i < NDIG; i++) begin
            if (m_ovf)                 g = 8'hBF;
            else if (LZB && i > msd)   g = 8'hFF;
            else                       g = GLYPH[m_dig[i]];
            g[7] = ~m_dot[i];
            if (!EN[i] || (BLINK[i] && !on)) g = 8'hFF;
            r[8*i +: 8] = g;
        end
        return r;
    endfunction

    task automatic push_raw(input int target, input logic [47:0] hex, input logic busy, input int tag);
        exp_t e;
        e.cyc = target; e.hex = hex; e.busy = busy; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic push_model(input int target, input logic busy, input int tag);
        push_raw(target, model_hex(bcnt + (target - cyc)), busy, tag);
    endtask

    task automatic set_hex(input logic [23:0] din, input logic [5:0] dot);
        for (int i = 0; i < NDIG; i++) m_dig[i] = int'(din[4*i +: 4]);
        m_ovf = 0;
        m_dot = dot;
    endtask

    task automatic set_dec(input logic [23:0] din, input logic [5:0] dot);
        int v;
        int lim;
        v   = int'(din[BIN_W-1:0]);
        lim = 1;
        for (int i = 0; i < NDIG; i++) lim = lim * 10;
        m_ovf = (v >= lim);
        m_dot = dot;
        for (int i = 0; i < NDIG; i++) begin
            m_dig[i] = m_ovf ? 0 : v % 10;
            v = v / 10;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_live(input logic [5:0] en, input logic [5:0] blink, input logic lzb);
        EN = en; BLINK = blink; LZB = lzb;
    endtask

    // One load transaction; stray LOADs are thrown in during CONV and COMMIT.
    task automatic do_load(input bit mode, input logic [23:0] din, input logic [5:0] dot,
                           input int tag, input int hold);
        int n;
        n = cyc;
        LOAD = 1'b1; MODE = mode; DIN = din; DOT = dot;
        if (!mode) begin
            push_model(n + 1, 1'b0, tag);
            set_hex(din, dot);
            for (int i = 0; i <= hold; i++) push_model(n + 2 + i, 1'b0, tag);
            tick();
            LOAD = 1'b0;
            DIN  = 24'($urandom);
            while (cyc < n + 2 + hold) tick();
        end else begin
            push_model(n + 1, 1'b1, tag);
            push_model(n + 12, 1'b1, tag);
            push_model(n + 21, 1'b1, tag);
            push_model(n + 22, 1'b0, tag);
            set_dec(din, dot);
            for (int i = 0; i <= hold; i++) push_model(n + 23 + i, 1'b0, tag);
            tick();
            while (cyc < n + 23 + hold) begin
                LOAD = (cyc == n + 5) || (cyc == n + 21);
                if (LOAD) begin
                    DIN  = 24'($urandom);
                    MODE = 1'($urandom);
                    DOT  = 6'($urandom);
                end
                tick();
            end
            LOAD = 1'b0;
        end
    endtask

    // Monitor: compares every expectation whose cycle has come up.
    always @(negedge CLK) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                total++; bad++;
                $display("FAIL stale tag=%0d due_cyc=%0d now=%0d", e.tag, e.cyc, cyc);
            end else begin
                total++;
                if (nHEX !== e.hex) begin
                    bad++;
                    $display("FAIL nhex tag=%0d cyc=%0d got=%h exp=%h", e.tag, cyc, nHEX, e.hex);
                end
                total++;
                if (BUSY !== e.busy) begin
                    bad++;
                    $display("FAIL busy tag=%0d cyc=%0d got=%b exp=%b", e.tag, cyc, BUSY, e.busy);
                end
            end
        end
        if (drain_timeout && !drain_counted) begin
            total++; bad++;
            drain_counted = 1;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < NDIG; i++) m_dig[i] = 0;
        m_ovf = 0;
        m_dot = '0;

        // Reset state
        repeat (3) tick();
        push_raw(cyc, 48'hFFFF_FFFF_FFFF, 1'b0, 1);
        nRST = 1'b1;

        // Directed cases
        set_live(6'h3F, 6'h00, 1'b0);
        do_load(1'b0, 24'h0123AF, 6'h00, 2, 1);
        do_load(1'b1, 24'd999999, 6'h00, 3, 1);
        do_load(1'b1, 24'd1000000, 6'h00, 4, 1);
        set_live(6'h3F, 6'h00, 1'b1);
        do_load(1'b1, 24'd0, 6'h00, 5, 1);
        do_load(1'b0, 24'h000050, 6'h10, 6, 1);
        set_live(6'h3D, 6'h01, 1'b0);
        do_load(1'b0, 24'h987654, 6'h02, 7, 10);

        // Reset during conversion step 10, then a normal hex load
        set_live(6'h3F, 6'h00, 1'b0);
        n = cyc;
        LOAD = 1'b1; MODE = 1'b1; DIN = 24'd123456; DOT = 6'h3F;
        push_model(n + 1, 1'b1, 8);
        tick();
        LOAD = 1'b0;
        repeat (10) tick();
        nRST = 1'b0;
        for (int i = 0; i < NDIG; i++) m_dig[i] = 0;
        m_ovf = 0;
        m_dot = '0;
        push_raw(cyc, 48'hFFFF_FFFF_FFFF, 1'b0, 8);
        tick();
        tick();
        push_raw(cyc, 48'hFFFF_FFFF_FFFF, 1'b0, 8);
        nRST = 1'b1;
        do_load(1'b0, 24'hC0FFEE, 6'h21, 9, 2);

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            logic [23:0] din;
            set_live(6'($urandom), ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00, 1'($urandom));
            case ($urandom_range(0, 3))
                0:       din = 24'($urandom_range(0, 120));
                1:       din = 24'($urandom_range(990000, 1048575));
                default: din = 24'($urandom);
            endcase
            do_load(1'($urandom), din, 6'($urandom), 100 + t, int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 60 && q.size() > 0; i++) tick();
        if (q.size() > 0) drain_timeout = 1;
        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
